// File: rtl/commit_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// commit_bus_arbiter_pkg
//
// Shared definitions for the commit/write-back bus: packet width, the bit
// ranges of each packet field, the packed packet view, and a helper that
// assembles a packet from its fields.
//
// Packet layout (MSB .. LSB):
//   RSID[3:0] | WE | DST[7:0] | X[15:0] | Y[15:0] | Z[15:0]
// -----------------------------------------------------------------------------
package commit_bus_arbiter_pkg;

    // Field widths
    localparam int COMMIT_RSID_W  = 4;
    localparam int COMMIT_WE_W    = 1;
    localparam int COMMIT_DST_W   = 8;
    localparam int COMMIT_COORD_W = 16;

    localparam int COMMIT_PACKET_SIZE = COMMIT_RSID_W + COMMIT_WE_W + COMMIT_DST_W
                                      + 3 * COMMIT_COORD_W;

    // Field LSB positions inside a packet
    localparam int COMMIT_Z_LSB    = 0;
    localparam int COMMIT_Y_LSB    = COMMIT_Z_LSB + COMMIT_COORD_W;
    localparam int COMMIT_X_LSB    = COMMIT_Y_LSB + COMMIT_COORD_W;
    localparam int COMMIT_DST_LSB  = COMMIT_X_LSB + COMMIT_COORD_W;
    localparam int COMMIT_WE_LSB   = COMMIT_DST_LSB + COMMIT_DST_W;
    localparam int COMMIT_RSID_LSB = COMMIT_WE_LSB + COMMIT_WE_W;

    // Field MSB positions (inclusive)
    localparam int COMMIT_Z_MSB    = COMMIT_Y_LSB - 1;
    localparam int COMMIT_Y_MSB    = COMMIT_X_LSB - 1;
    localparam int COMMIT_X_MSB    = COMMIT_DST_LSB - 1;
    localparam int COMMIT_DST_MSB  = COMMIT_WE_LSB - 1;
    localparam int COMMIT_WE_MSB   = COMMIT_RSID_LSB - 1;
    localparam int COMMIT_RSID_MSB = COMMIT_PACKET_SIZE - 1;

    // Width of the granted-station index; covers up to 16 stations.
    localparam int GRANT_ID_W   = 4;
    localparam int MAX_STATIONS = 16;

    // Packed view of a packet; member order matches the ranges above.
    typedef struct packed {
        logic [COMMIT_RSID_W-1:0]  rsid;
        logic                      we;
        logic [COMMIT_DST_W-1:0]   dst;
        logic [COMMIT_COORD_W-1:0] x;
        logic [COMMIT_COORD_W-1:0] y;
        logic [COMMIT_COORD_W-1:0] z;
    } commit_packet_t;

    // Assemble a flat packet from its fields.
    function automatic logic [COMMIT_PACKET_SIZE-1:0] makePacket(
        input logic [COMMIT_RSID_W-1:0]  rsid,
        input logic                      we,
        input logic [COMMIT_DST_W-1:0]   dst,
        input logic [COMMIT_COORD_W-1:0] x,
        input logic [COMMIT_COORD_W-1:0] y,
        input logic [COMMIT_COORD_W-1:0] z
    );
        commit_packet_t p;
        p.rsid = rsid;
        p.we   = we;
        p.dst  = dst;
        p.x    = x;
        p.y    = y;
        p.z    = z;
        return p;
    endfunction

endpackage

// File: rtl/commit_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// commit_bus_arbiter_if
//
// Bundle between the reservation stations and the commit bus arbiter.
//   iCommitRequest  stations -> arbiter  bit i = station i has a result pending
//   iCommitData     stations -> arbiter  station i packet at [i*PACKET_W +: PACKET_W]
//   iStall          regfile  -> arbiter  write port busy, no grant this cycle
//   oCommitGranted  arbiter  -> stations one-hot, one-cycle grant pulse
//   oCommitValid    arbiter  -> consumers oCommitBus holds a valid packet
//   oCommitBus      arbiter  -> consumers committed packet
//   oLastGrantId    arbiter  -> consumers index of the most recent winner
//
// Modports: master = arbiter side, slave = station/register-file side.
// -----------------------------------------------------------------------------
interface commit_bus_arbiter_if
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = 4,
    parameter int PACKET_W     = COMMIT_PACKET_SIZE
) ();

    logic [NUM_STATIONS-1:0]          iCommitRequest;
    logic [NUM_STATIONS*PACKET_W-1:0] iCommitData;
    logic                             iStall;
    logic [NUM_STATIONS-1:0]          oCommitGranted;
    logic                             oCommitValid;
    logic [PACKET_W-1:0]              oCommitBus;
    logic [GRANT_ID_W-1:0]            oLastGrantId;

    modport master (
        input  iCommitRequest,
        input  iCommitData,
        input  iStall,
        output oCommitGranted,
        output oCommitValid,
        output oCommitBus,
        output oLastGrantId
    );

    modport slave (
        output iCommitRequest,
        output iCommitData,
        output iStall,
        input  oCommitGranted,
        input  oCommitValid,
        input  oCommitBus,
        input  oLastGrantId
    );

endinterface

// File: rtl/commit_bus_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//
// Purely combinational round-robin picker. Finds the first set bit of elig
// starting at index pointer and wrapping modulo NUM_STATIONS.
//
// Ports:
//   elig          in   NUM_STATIONS  eligible requesters
//   pointer       in   GRANT_ID_W    search start index (< NUM_STATIONS)
//   winnerOneHot  out  NUM_STATIONS  one-hot winner, zero when nothing eligible
//   winnerIdx     out  GRANT_ID_W    binary winner index, zero when nothing eligible
//   anyValid      out  1             at least one eligible requester
// -----------------------------------------------------------------------------
module rr_priority_picker
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = 4
) (
    input  logic [NUM_STATIONS-1:0] elig,
    input  logic [GRANT_ID_W-1:0]   pointer,
    output logic [NUM_STATIONS-1:0] winnerOneHot,
    output logic [GRANT_ID_W-1:0]   winnerIdx,
    output logic                    anyValid
);

    // Work on a fixed 16-bit view so the variable index is always in range
    // regardless of NUM_STATIONS.
    logic [MAX_STATIONS-1:0] eligExt;
    logic [MAX_STATIONS-1:0] oneHotExt;

    assign eligExt = MAX_STATIONS'(elig);

    always_comb begin
        logic [GRANT_ID_W:0] cand;
        cand      = '0;
        oneHotExt = '0;
        winnerIdx = '0;
        anyValid  = 1'b0;
        for (int k = 0; k < NUM_STATIONS; k++) begin
            // pointer < NUM_STATIONS, so one conditional subtract is enough
            // to wrap pointer + k back into range.
            cand = {1'b0, pointer} + (GRANT_ID_W + 1)'(k);
            if (cand >= (GRANT_ID_W + 1)'(NUM_STATIONS)) begin
                cand = cand - (GRANT_ID_W + 1)'(NUM_STATIONS);
            end
            if (!anyValid && eligExt[cand[GRANT_ID_W-1:0]]) begin
                anyValid                          = 1'b1;
                winnerIdx                         = cand[GRANT_ID_W-1:0];
                oneHotExt[cand[GRANT_ID_W-1:0]]   = 1'b1;
            end
        end
    end

    assign winnerOneHot = oneHotExt[NUM_STATIONS-1:0];

endmodule

// File: rtl/commit_bus_arbiter.sv
// -----------------------------------------------------------------------------
// commit_bus_arbiter
//
// Shares the single commit/write-back bus among NUM_STATIONS reservation
// stations. Each cycle the round-robin picker chooses one eligible requester;
// on the next edge the arbiter pulses its grant for one cycle and registers
// its packet onto the commit bus.
//
// A station granted in cycle t still holds its request during t+1 (it drops
// the request one cycle after seeing the grant), so the current grant vector
// doubles as a hold-off mask that keeps it from being granted twice.
//
// Ports:
//   Clock   in  system clock, rising edge
//   Reset   in  asynchronous, active-high reset; clears every register
//   bus     commit_bus_arbiter_if.master (request/data/stall in,
//           grant/valid/bus/last-id out)
//
// NUM_STATIONS must be in 2..16; the interface instance must use the same
// NUM_STATIONS and PACKET_W as this module.
// -----------------------------------------------------------------------------
module commit_bus_arbiter
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = 4,
    parameter int PACKET_W     = COMMIT_PACKET_SIZE
) (
    input  logic                  Clock,
    input  logic                  Reset,
    commit_bus_arbiter_if.master  bus
);

    // Registered state
    logic [NUM_STATIONS-1:0] grantQ;
    logic                    validQ;
    logic [PACKET_W-1:0]     busQ;
    logic [GRANT_ID_W-1:0]   lastIdQ;
    logic [GRANT_ID_W-1:0]   rotPtr;

    // Selection
    logic [NUM_STATIONS-1:0] holdMask;
    logic [NUM_STATIONS-1:0] elig;
    logic [NUM_STATIONS-1:0] winOneHot;
    logic [GRANT_ID_W-1:0]   winIdx;
    logic                    anyElig;
    logic                    grantFire;
    logic [GRANT_ID_W-1:0]   nextPtr;
    logic [PACKET_W-1:0]     winPacket;

    assign holdMask  = grantQ;
    assign elig      = bus.iCommitRequest & ~holdMask;
    assign grantFire = anyElig & ~bus.iStall;

    rr_priority_picker #(
        .NUM_STATIONS (NUM_STATIONS)
    ) picker (
        .elig         (elig),
        .pointer      (rotPtr),
        .winnerOneHot (winOneHot),
        .winnerIdx    (winIdx),
        .anyValid     (anyElig)
    );

    // Next pointer is the slot after the winner, wrapping at the last station.
    assign nextPtr = (winIdx == GRANT_ID_W'(NUM_STATIONS - 1)) ? '0 : winIdx + 1'b1;

    // AND-OR mux of the station packets keyed by the one-hot winner.
    logic [PACKET_W-1:0] orChain [NUM_STATIONS+1];

    assign orChain[0] = '0;

    for (genvar g = 0; g < NUM_STATIONS; g++) begin : gPktMux
        assign orChain[g+1] = orChain[g]
                            | (winOneHot[g] ? bus.iCommitData[g*PACKET_W +: PACKET_W] : '0);
    end

    assign winPacket = orChain[NUM_STATIONS];

    // Grant/bus register stage: bus payload, pointer and last id only move on
    // a grant; grant and valid are single-cycle pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            grantQ  <= '0;
            validQ  <= 1'b0;
            busQ    <= '0;
            lastIdQ <= '0;
            rotPtr  <= '0;
        end else if (grantFire) begin
            grantQ  <= winOneHot;
            validQ  <= 1'b1;
            busQ    <= winPacket;
            lastIdQ <= winIdx;
            rotPtr  <= nextPtr;
        end else begin
            grantQ  <= '0;
            validQ  <= 1'b0;
        end
    end

    assign bus.oCommitGranted = grantQ;
    assign bus.oCommitValid   = validQ;
    assign bus.oCommitBus     = busQ;
    assign bus.oLastGrantId   = lastIdQ;

endmodule

// File: tb/tb_commit_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_commit_bus_arbiter
//
// Drives the arbiter with directed scenarios followed by randomized traffic.
// Stations follow the request protocol: hold request and packet until
// granted, drop one cycle after the grant, optionally re-raise with new data.
// A reference model computes the grant from the round-robin rule each cycle.
// -----------------------------------------------------------------------------
module tb_commit_bus_arbiter;
    import commit_bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int PW = COMMIT_PACKET_SIZE;
    localparam int IW = $clog2(N);

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    commit_bus_arbiter_if #(.NUM_STATIONS(N), .PACKET_W(PW)) busIf ();

    commit_bus_arbiter #(
        .NUM_STATIONS (N),
        .PACKET_W     (PW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (busIf)
    );

    always #5 Clock = ~Clock;

    // Station side
    logic [N-1:0]  req;
    logic [N-1:0]  prevSeen;
    logic [N-1:0]  reraise;
    logic [PW-1:0] pkt [N];
    logic          stall;
    int            randPct;
    int            seqCnt;

    // Reference model
    int            mPtr;
    int            mLast;
    logic [N-1:0]  mGrant;
    logic          mValid;
    logic [PW-1:0] mBus;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] nextPacket(input int i);
        logic [PW-1:0] p;
        p = makePacket(4'(i), 1'b1, 8'(16 + i), 16'(16'hA0 + i), 16'(seqCnt), 16'(~seqCnt));
        seqCnt++;
        return p;
    endfunction

    task automatic applyInputs();
        busIf.iCommitRequest = req;
        busIf.iStall         = stall;
        for (int i = 0; i < N; i++) begin
            busIf.iCommitData[i*PW +: PW] = pkt[IW'(i)];
        end
    endtask

    task automatic modelReset();
        mPtr   = 0;
        mLast  = 0;
        mGrant = '0;
        mValid = 1'b0;
        mBus   = '0;
    endtask

    // Round-robin rule: eligible = requesting and not granted last cycle;
    // winner is the first eligible index at or after the pointer, wrapping.
    task automatic modelStep();
        logic [N-1:0] elig;
        int w;
        elig = req & ~mGrant;
        w = -1;
        if (elig != '0 && !stall) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mPtr + k) % N;
                if (w < 0 && ((elig >> idx) & N'(1)) != '0) w = idx;
            end
            mGrant = N'(1) << w;
            mValid = 1'b1;
            mBus   = pkt[IW'(w)];
            mPtr   = (w + 1) % N;
            mLast  = w;
        end else begin
            mGrant = '0;
            mValid = 1'b0;
        end
    endtask

    task automatic checkOutputs(input string tag);
        chk({tag, ".grant"}, 64'(busIf.oCommitGranted), 64'(mGrant));
        chk({tag, ".valid"}, 64'(busIf.oCommitValid),   64'(mValid));
        chk({tag, ".bus"},   64'(busIf.oCommitBus),     64'(mBus));
        chk({tag, ".last"},  64'(busIf.oLastGrantId),   64'(mLast));
    endtask

    // Station reaction after observing the outputs of this cycle.
    task automatic stationUpdate();
        for (int i = 0; i < N; i++) begin
            if (prevSeen[IW'(i)]) begin
                req[IW'(i)] = 1'b0;
                if (reraise[IW'(i)]) begin
                    req[IW'(i)] = 1'b1;
                    pkt[IW'(i)] = nextPacket(i);
                end
            end
            if (!req[IW'(i)] && randPct > 0 && int'($urandom_range(99)) < randPct) begin
                req[IW'(i)] = 1'b1;
                pkt[IW'(i)] = PW'({$urandom(), $urandom()});
            end
        end
        prevSeen = mGrant;
    endtask

    task automatic cycle(input string tag);
        applyInputs();
        modelStep();
        @(posedge Clock);
        #1;
        checkOutputs(tag);
        stationUpdate();
    endtask

    // Asynchronous reset, checked before any clock edge can intervene.
    task automatic doReset(input string tag);
        Reset = 1'b1;
        #1;
        modelReset();
        req      = '0;
        prevSeen = '0;
        reraise  = '0;
        stall    = 1'b0;
        randPct  = 0;
        applyInputs();
        checkOutputs(tag);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        seqCnt = 0;
        for (int i = 0; i < N; i++) pkt[IW'(i)] = '0;
        doReset("reset0");

        // Reset mid-grant, then stations 0 and 2 compete from pointer 0
        req[1] = 1'b1; pkt[1] = nextPacket(1);
        cycle("pre_rst");
        chk("pre_rst_valid", 64'(busIf.oCommitValid), 64'(1));
        doReset("rst_mid");
        req[0] = 1'b1; pkt[0] = nextPacket(0);
        req[2] = 1'b1; pkt[2] = nextPacket(2);
        cycle("rst_after");
        chk("rst_first_grant", 64'(busIf.oCommitGranted), 64'(4'b0001));
        cycle("rst_after2");
        chk("rst_second_grant", 64'(busIf.oCommitGranted), 64'(4'b0100));
        cycle("rst_after3");

        // Single requester
        doReset("rst_single");
        req[1] = 1'b1; pkt[1] = nextPacket(1);
        cycle("single");
        chk("single_grant", 64'(busIf.oCommitGranted), 64'(4'b0010));
        chk("single_bus",   64'(busIf.oCommitBus),     64'(pkt[1]));
        chk("single_last",  64'(busIf.oLastGrantId),   64'(1));
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cycle("single_tail");
            if (busIf.oCommitGranted != '0) cnt++;
        end
        chk("single_no_regrant", 64'(cnt), 64'(0));

        // All four requesting continuously, distinct packets per station
        doReset("rst_all4");
        reraise = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req[IW'(i)] = 1'b1;
            pkt[IW'(i)] = nextPacket(i);
        end
        for (int k = 0; k < 12; k++) begin
            cycle("all4");
            chk("all4_order", 64'(busIf.oLastGrantId), 64'(k % 4));
            chk("all4_valid", 64'(busIf.oCommitValid), 64'(1));
        end

        // Back-to-back from station 3 only, then pointer wrap
        doReset("rst_b2b");
        reraise = 4'b1000;
        req[3] = 1'b1; pkt[3] = nextPacket(3);
        for (int k = 0; k < 8; k++) begin
            cycle("b2b");
            chk("b2b_grant", 64'(busIf.oCommitGranted), 64'((k % 2 == 0) ? 4'b1000 : 4'b0000));
        end
        reraise = '0;
        for (int k = 0; k < 3; k++) cycle("b2b_drain");
        req[1] = 1'b1; pkt[1] = nextPacket(1);
        req[2] = 1'b1; pkt[2] = nextPacket(2);
        cycle("wrap");
        chk("wrap_grant", 64'(busIf.oCommitGranted), 64'(4'b0010));
        cycle("wrap2");
        chk("wrap_grant2", 64'(busIf.oCommitGranted), 64'(4'b0100));
        cycle("wrap3");

        // Stall holds off grants; rotation resumes afterwards
        doReset("rst_stall");
        req[1] = 1'b1; pkt[1] = nextPacket(1);
        req[2] = 1'b1; pkt[2] = nextPacket(2);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("stall");
            chk("stall_grant", 64'(busIf.oCommitGranted), 64'(0));
            chk("stall_valid", 64'(busIf.oCommitValid),   64'(0));
        end
        stall = 1'b0;
        cycle("unstall1");
        chk("unstall_first",  64'(busIf.oCommitGranted), 64'(4'b0010));
        cycle("unstall2");
        chk("unstall_second", 64'(busIf.oCommitGranted), 64'(4'b0100));
        cycle("unstall3");
        chk("unstall_idle",   64'(busIf.oCommitGranted), 64'(0));

        // Randomized traffic with random stalls and packets
        doReset("rst_rand");
        randPct = 40;
        for (int k = 0; k < 300; k++) begin
            stall = ($urandom_range(3) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
